frame_deserializer: RTL and testbench

//   Receive-side partner of the load-triggered 4-beat serializer: captures one DATA_W-bit beat per clock

---
 rtl/frame_deserializer.sv | 130 +++++++++++++
 tb/tb_frame_deserializer.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/frame_deserializer.sv
// Assembles BEATS serial beats of DATA_W bits, framed by sof_in, into one parallel word.
// Latency: the word is valid one clock after its final beat is on din.
// Backpressure: one output register; a frame that completes while that register is full is dropped and flagged.
module frame_deserializer #(
    parameter int DATA_W = 2,
    parameter int BEATS  = 4,
    parameter int CNT_W  = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      sof_in,
    input  logic [DATA_W-1:0]         din,
    output logic [BEATS*DATA_W-1:0]   word_out,
    output logic                      word_valid,
    input  logic                      word_ready,
    output logic                      busy,
    output logic [CNT_W-1:0]          beat_cnt,
    output logic                      abort_err,
    output logic                      overrun_err,
    input  logic                      clr_err
);

    localparam int WORD_W = BEATS * DATA_W;
    localparam int LOW_W  = WORD_W - DATA_W;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [WORD_W-1:0]    sreg_q, sreg_d;
    logic [WORD_W-1:0]    word_q, word_d;
    logic                 valid_q, valid_d;
    logic                 abort_q, abort_d;
    logic                 overrun_q, overrun_d;

    logic                 frame_done;
    logic                 abort_evt;
    logic                 out_free;
    logic                 load_word;
    logic                 overrun_evt;
    logic [WORD_W-1:0]    frame_word;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            sreg_q    <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            abort_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            sreg_q    <= sreg_d;
            word_q    <= word_d;
            valid_q   <= valid_d;
            abort_q   <= abort_d;
            overrun_q <= overrun_d;
        end
    end

    // sof_in always restarts framing, even mid-frame and even on what would be the final beat.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        frame_done = 1'b0;
        abort_evt  = 1'b0;
        case (state_q)
            IDLE: begin
                if (sof_in) begin
                    state_d = RECV;
                    cnt_d   = CNT_ONE;
                end
            end
            RECV: begin
                if (sof_in) begin
                    abort_evt = 1'b1;
                    cnt_d     = CNT_ONE;
                end else if (cnt_q == LAST_BEAT) begin
                    state_d    = IDLE;
                    cnt_d      = '0;
                    frame_done = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        frame_word  = {sreg_q[LOW_W-1:0], din};
        sreg_d      = (sof_in || state_q == RECV) ? frame_word : sreg_q;

        // The output slot is free if empty or being drained on this very edge.
        out_free    = !valid_q || word_ready;
        load_word   = frame_done && out_free;
        overrun_evt = frame_done && !out_free;

        word_d      = load_word ? frame_word : word_q;
        if (load_word) begin
            valid_d = 1'b1;
        end else if (valid_q && word_ready) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // A new event in the clear cycle still sets the flag.
        abort_d     = abort_evt   | (abort_q   & ~clr_err);
        overrun_d   = overrun_evt | (overrun_q & ~clr_err);
    end

    assign busy        = (state_q == RECV);
    assign beat_cnt    = cnt_q;
    assign word_out    = word_q;
    assign word_valid  = valid_q;
    assign abort_err   = abort_q;
    assign overrun_err = overrun_q;

endmodule

// File: tb/tb_frame_deserializer.sv
// Scoreboard bench for frame_deserializer: directed frames plus randomized framing, backpressure and error clears.
module tb_frame_deserializer;

    localparam int DATA_W = 2;
    localparam int BEATS  = 4;
    localparam int CNT_W  = 2;
    localparam int WORD_W = BEATS * DATA_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              sof_in = 1'b0;
    logic [DATA_W-1:0] din = '0;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              word_ready = 1'b0;
    logic              busy;
    logic [CNT_W-1:0]  beat_cnt;
    logic              abort_err;
    logic              overrun_err;
    logic              clr_err = 1'b0;

    frame_deserializer #(.DATA_W(DATA_W), .BEATS(BEATS), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .sof_in(sof_in), .din(din),
        .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
        .busy(busy), .beat_cnt(beat_cnt), .abort_err(abort_err),
        .overrun_err(overrun_err), .clr_err(clr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Words the bench expects the consumer to receive, in order.
    logic [WORD_W-1:0] exp_q[$];

    // Reference model: beats of the frame in flight, the output slot, and the sticky flags.
    logic [DATA_W-1:0] m_beats[$];
    bit                m_valid;
    logic [WORD_W-1:0] m_word;
    bit                m_abort;
    bit                m_ovr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_beats.delete();
        exp_q.delete();
        m_valid = 0;
        m_word  = '0;
        m_abort = 0;
        m_ovr   = 0;
    endtask

    // Applies the rules for one clock edge given the inputs held during that cycle.
    task automatic model_edge(input bit s, input logic [DATA_W-1:0] d, input bit r, input bit c);
        bit ev_abort = 0;
        bit ev_ovr   = 0;
        bit done     = 0;
        logic [WORD_W-1:0] w = '0;
        if (s) begin
            if (m_beats.size() > 0) ev_abort = 1;
            m_beats.delete();
            m_beats.push_back(d);
        end else if (m_beats.size() > 0) begin
            m_beats.push_back(d);
            if (m_beats.size() == BEATS) begin
                foreach (m_beats[i]) w = (w << DATA_W) | WORD_W'(m_beats[i]);
                m_beats.delete();
                done = 1;
            end
        end
        if (done && (!m_valid || r)) begin
            m_word  = w;
            m_valid = 1;
            exp_q.push_back(w);
        end else begin
            if (done) ev_ovr = 1;
            if (m_valid && r) m_valid = 0;
        end
        m_abort = ev_abort | (m_abort & !c);
        m_ovr   = ev_ovr   | (m_ovr   & !c);
    endtask

    task automatic check_state();
        check("word_valid", 32'(word_valid), 32'(m_valid));
        check("busy", 32'(busy), 32'(m_beats.size() > 0));
        check("beat_cnt", 32'(beat_cnt), 32'(m_beats.size()));
        check("abort_err", 32'(abort_err), 32'(m_abort));
        check("overrun_err", 32'(overrun_err), 32'(m_ovr));
        if (m_valid) check("word_out_held", 32'(word_out), 32'(m_word));
    endtask

    task automatic cycle(input bit s, input logic [DATA_W-1:0] d, input bit r, input bit c);
        sof_in     = s;
        din        = d;
        word_ready = r;
        clr_err    = c;
        model_edge(s, d, r, c);
        @(posedge clk);
        #1;
        check_state();
    endtask

    task automatic do_reset();
        rst_n      = 1'b0;
        sof_in     = 1'b0;
        word_ready = 1'b0;
        clr_err    = 1'b0;
        model_reset();
        #1;
        check("rst_word_out", 32'(word_out), 32'h0);
        check("rst_word_valid", 32'(word_valid), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_beat_cnt", 32'(beat_cnt), 32'h0);
        check("rst_flags", 32'({abort_err, overrun_err}), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // Consumer-side monitor: every accepted word must be the next one the model produced.
    always @(negedge clk) begin
        if (rst_n && word_valid && word_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_word", 32'(word_out), 32'hFFFF_FFFF);
            end else begin
                check("sb_word", 32'(word_out), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        @(posedge clk);
        #1;
        do_reset();

        // Single frame 3,1,2,0 with the consumer ready.
        cycle(1, 2'd3, 1, 0);
        cycle(0, 2'd1, 1, 0);
        cycle(0, 2'd2, 1, 0);
        cycle(0, 2'd0, 1, 0);
        check("t1_word", 32'(word_out), 32'hD8);
        check("t1_valid", 32'(word_valid), 32'h1);
        cycle(0, 2'd0, 1, 0);
        check("t1_valid_drop", 32'(word_valid), 32'h0);

        // Back-to-back frames with the consumer stalled: second frame overruns.
        cycle(1, 2'd3, 0, 0);
        cycle(0, 2'd1, 0, 0);
        cycle(0, 2'd2, 0, 0);
        cycle(0, 2'd0, 0, 0);
        cycle(1, 2'd0, 0, 0);
        cycle(0, 2'd1, 0, 0);
        cycle(0, 2'd2, 0, 0);
        cycle(0, 2'd3, 0, 0);
        check("t2_word_held", 32'(word_out), 32'hD8);
        check("t2_overrun", 32'(overrun_err), 32'h1);
        cycle(0, 2'd0, 1, 0);
        check("t2_valid_drop", 32'(word_valid), 32'h0);

        // Restart at beat 2; only the new frame 1,1,1,1 is delivered.
        cycle(1, 2'd3, 1, 0);
        cycle(0, 2'd1, 1, 0);
        cycle(1, 2'd1, 1, 0);
        cycle(0, 2'd1, 1, 0);
        cycle(0, 2'd1, 1, 0);
        cycle(0, 2'd1, 1, 0);
        check("t3_word", 32'(word_out), 32'h55);
        check("t3_abort", 32'(abort_err), 32'h1);
        cycle(0, 2'd0, 1, 0);

        // Clear both flags, then clear coincident with a new abort.
        cycle(0, 2'd0, 1, 1);
        check("t6_cleared", 32'({abort_err, overrun_err}), 32'h0);
        cycle(1, 2'd2, 1, 0);
        cycle(1, 2'd2, 1, 1);
        check("t6_set_wins", 32'(abort_err), 32'h1);

        // Reset mid-frame, then a clean frame.
        cycle(0, 2'd2, 1, 0);
        do_reset();
        cycle(1, 2'd0, 1, 0);
        cycle(0, 2'd1, 1, 0);
        cycle(0, 2'd2, 1, 0);
        cycle(0, 2'd3, 1, 0);
        check("t4_word", 32'(word_out), 32'h1B);

        // Output drains on the same edge the next frame lands: no overrun.
        cycle(1, 2'd3, 0, 0);
        cycle(0, 2'd1, 0, 0);
        cycle(0, 2'd2, 0, 0);
        cycle(0, 2'd0, 1, 0);
        check("t5_word", 32'(word_out), 32'hD8);
        check("t5_overrun", 32'(overrun_err), 32'h0);

        // Randomized framing, backpressure, clears and occasional reset.
        for (int n = 0; n < 2000; n++) begin
            bit s;
            if ($urandom_range(0, 599) == 0) begin
                do_reset();
            end else begin
                if (m_beats.size() > 0) s = ($urandom_range(0, 15) == 0);
                else                    s = ($urandom_range(0, 2) == 0);
                cycle(s, DATA_W'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                      ($urandom_range(0, 31) == 0));
            end
        end

        for (int n = 0; n < 4; n++) cycle(0, 2'd0, 1, 0);
        check("sb_drained", 32'(exp_q.size()), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
